// File: rtl/stage3_exec_unit.sv
// -----------------------------------------------------------------------------
// stage3_exec_unit
//
// Stage-3 execute block. A WIDTH-bit ALU result (or the externally supplied
// shifter result) is loaded into a write-enabled result register. An optional
// iterative shift-add multiplier (ALUop 7) can be compiled in. While it runs,
// the block raises Stall so that upstream holds its inputs.
//
// Build option:
//   STAGE3_MUL_EN  defined   -> multiplier FSM present; ALUop 7 = low WIDTH
//                               bits of A*B, latency WIDTH+2 edges.
//                  undefined -> no multiplier; ALUop 7 yields 0, Stall = 0.
//
// Parameters:
//   WIDTH       datapath width (>= 4)
//   SIGNED_SLT  0: SLT unsigned, 1: SLT two's-complement
//
// Ports:
//   CLK         clock, rising edge
//   Reset       synchronous active-high reset
//   ALUInA/B    operands
//   ALUop       operation select (0 AND, 1 OR, 2 ADD, 6 SUB, 4 SLT, 7 MUL)
//   ShifterOut  shifter result, selected when ResSource = 1
//   ResSource   0: ALU result, 1: ShifterOut
//   ResWrite    result register write enable
//   ResOut      registered result
//   isZero      combinational, ALU result == 0
//   Stall       combinational, multiply in progress
// -----------------------------------------------------------------------------
module stage3_exec_unit #(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] ALUInA,
    input  logic [WIDTH-1:0] ALUInB,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] ShifterOut,
    input  logic             ResSource,
    input  logic             ResWrite,
    output logic [WIDTH-1:0] ResOut,
    output logic             isZero,
    output logic             Stall
);

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;
    logic             slt_bit;
    logic [WIDTH-1:0] res_q;

`ifdef STAGE3_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_req;

    assign mul_req = (ALUop == 4'd7) && !ResSource;
    assign Stall   = mul_req && (state_q != DONE);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (mul_req) begin
                    mcand_d  = ALUInA;
                    mplier_d = ALUInB;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!mul_req) begin
                    // Upstream moved on: drop the partial product.
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The accumulator stands in as the ALU result for op 7, so isZero
    // tracks the running product and is meaningful once DONE is reached.
    assign mul_result = acc_q;
    assign mul_done   = (state_q == DONE);
`else
    assign Stall      = 1'b0;
    assign mul_result = '0;
    assign mul_done   = 1'b0;
`endif

    always_comb begin
        if (SIGNED_SLT) begin
            slt_bit = ($signed(ALUInA) < $signed(ALUInB));
        end else begin
            slt_bit = (ALUInA < ALUInB);
        end
    end

    always_comb begin
        alu_result = '0;
        case (ALUop)
            4'd0:    alu_result = ALUInA & ALUInB;
            4'd1:    alu_result = ALUInA | ALUInB;
            4'd2:    alu_result = ALUInA + ALUInB;
            4'd6:    alu_result = ALUInA - ALUInB;
            4'd4:    alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            4'd7:    alu_result = mul_result;
            default: alu_result = '0;
        endcase
    end

    assign isZero = (alu_result == '0);

    // Result register: DONE commits the product; otherwise a normal
    // single-cycle write unless the multiplier is holding the pipe.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            res_q <= '0;
        end else if (mul_done) begin
            if (ResWrite) begin
                res_q <= mul_result;
            end
        end else if (!Stall && ResWrite) begin
            res_q <= ResSource ? ShifterOut : alu_result;
        end
    end

    assign ResOut = res_q;

endmodule

// File: tb/tb_stage3_exec_unit.sv
module tb_stage3_exec_unit;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [W-1:0] ALUInA, ALUInB, ShifterOut;
    logic [3:0]   ALUop;
    logic         ResSource, ResWrite;
    logic [W-1:0] res_u, res_s;
    logic         zero_u, zero_s, stall_u, stall_s;

    always #5 CLK = ~CLK;

    stage3_exec_unit #(.WIDTH(W), .SIGNED_SLT(1'b0)) dut_u (
        .CLK(CLK), .Reset(Reset), .ALUInA(ALUInA), .ALUInB(ALUInB),
        .ALUop(ALUop), .ShifterOut(ShifterOut), .ResSource(ResSource),
        .ResWrite(ResWrite), .ResOut(res_u), .isZero(zero_u), .Stall(stall_u)
    );

    stage3_exec_unit #(.WIDTH(W), .SIGNED_SLT(1'b1)) dut_s (
        .CLK(CLK), .Reset(Reset), .ALUInA(ALUInA), .ALUInB(ALUInB),
        .ALUop(ALUop), .ShifterOut(ShifterOut), .ResSource(ResSource),
        .ResWrite(ResWrite), .ResOut(res_s), .isZero(zero_s), .Stall(stall_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected contents of the two result registers.
    logic [W-1:0] exp_u, exp_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic.
    function automatic logic [W-1:0] ref_alu(input int op, input longint unsigned a,
                                             input longint unsigned b, input bit sgn);
        longint unsigned full = 64'd1 << W;
        longint sa, sb;
        longint unsigned r;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a >= full / 2) sa = sa - longint'(full);
        if (sgn && b >= full / 2) sb = sb - longint'(full);
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = (a + b) % full;
            6: r = (a + full - b) % full;
            4: r = sgn ? ((sa < sb) ? 1 : 0) : ((a < b) ? 1 : 0);
`ifdef STAGE3_MUL_EN
            7: r = (a * b) % full;
`endif
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One single-cycle operation: check combinational outputs, clock, check ResOut.
    task automatic do_op(input string tag, input int op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic src, input logic wr,
                         input logic [W-1:0] sh);
        logic [W-1:0] ru, rs;
        ALUop = 4'(op); ALUInA = a; ALUInB = b;
        ResSource = src; ResWrite = wr; ShifterOut = sh;
        #1;
        ru = ref_alu(op, a, b, 1'b0);
        rs = ref_alu(op, a, b, 1'b1);
        check({tag, "_zero_u"}, 32'(zero_u), 32'(ru == 0));
        check({tag, "_zero_s"}, 32'(zero_s), 32'(rs == 0));
        check({tag, "_stall"}, 32'(stall_u), 32'd0);
        if (wr) begin
            exp_u = src ? sh : ru;
            exp_s = src ? sh : rs;
        end
        tick();
        check({tag, "_res_u"}, 32'(res_u), 32'(exp_u));
        check({tag, "_res_s"}, 32'(res_s), 32'(exp_s));
        $display("[TB] %s op=%0d a=0x%h b=0x%h src=%0b wr=%0b res_u=0x%h res_s=0x%h",
                 tag, op, a, b, src, wr, res_u, res_s);
    endtask

`ifdef STAGE3_MUL_EN
    // Full multiply: count stall cycles, check DONE flags, then the write edge.
    task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wr);
        int stall_cycles = 0;
        logic [W-1:0] prod;
        prod = ref_alu(7, a, b, 1'b0);
        ALUop = 4'd7; ALUInA = a; ALUInB = b; ResSource = 1'b0; ResWrite = wr;
        #1;
        while (stall_u && stall_cycles < 4 * W) begin
            stall_cycles++;
            tick();
        end
        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(W + 1));
        check({tag, "_done_zero"}, 32'(zero_u), 32'(prod == 0));
        check({tag, "_hold"}, 32'(res_u), 32'(exp_u));
        if (wr) begin
            exp_u = prod;
            exp_s = prod;
        end
        tick();
        check({tag, "_res_u"}, 32'(res_u), 32'(exp_u));
        check({tag, "_res_s"}, 32'(res_s), 32'(exp_s));
        $display("[TB] %s MUL a=%0d b=%0d wr=%0b stall_cycles=%0d res=0x%h",
                 tag, a, b, wr, stall_cycles, res_u);
        ALUop = 4'd0; ResWrite = 1'b0;
    endtask
`endif

    initial begin
        int op;
        Reset = 1'b1; ALUInA = '0; ALUInB = '0; ALUop = 4'd0;
        ShifterOut = '0; ResSource = 1'b0; ResWrite = 1'b1;
        tick(); tick();
        exp_u = '0; exp_s = '0;
        check("reset_res_u", 32'(res_u), 32'd0);
        check("reset_res_s", 32'(res_s), 32'd0);
        check("reset_stall", 32'(stall_u), 32'd0);
        Reset = 1'b0;

        // Directed cases
        do_op("add_3_5",    2, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0000);
        do_op("add_wrap",   2, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000);
        do_op("sub_eq",     6, 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000);
        do_op("slt_3_ffff", 4, 16'h0003, 16'hFFFF, 1'b0, 1'b1, 16'h0000);
        do_op("shifter",    2, 16'h1111, 16'h2222, 1'b1, 1'b1, 16'h1234);
        do_op("and",        0, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 16'h0000);
        do_op("or",         1, 16'hF000, 16'h000F, 1'b0, 1'b1, 16'h0000);
        do_op("bad_op",     9, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            do_op("hold", 2, 16'(i), 16'h0100, 1'b0, 1'b0, 16'hBEEF);
        end
        // ALUop 7 with ResSource=1 is a plain shifter write in every build.
        do_op("mul_src1", 7, 16'h0012, 16'h0034, 1'b1, 1'b1, 16'h5A5A);
`ifndef STAGE3_MUL_EN
        do_op("mul_off", 7, 16'h0012, 16'h0034, 1'b0, 1'b1, 16'h0000);
`endif

        // Randomized single-cycle ops
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 15));
`ifdef STAGE3_MUL_EN
            if (op == 7) op = 2;
`endif
            do_op("rand", op, 16'($urandom), 16'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 16'($urandom));
        end

`ifdef STAGE3_MUL_EN
        do_mul("mul_300x7", 16'd300, 16'd7, 1'b1);
        check("mul_300x7_val", 32'(res_u), 32'h0834);
        do_mul("mul_zero", 16'h0100, 16'h0100, 1'b1);
        // Back-to-back: next MUL presented straight after DONE
        ALUop = 4'd7;
        do_mul("mul_b2b", 16'd1234, 16'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_mul("mul_rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Reset on edge 8 of a multiply
        ALUop = 4'd7; ALUInA = 16'd99; ALUInB = 16'd77; ResSource = 1'b0; ResWrite = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        Reset = 1'b1;
        tick();
        exp_u = '0; exp_s = '0;
        check("midreset_res", 32'(res_u), 32'd0);
        check("midreset_stall_idle", 32'(stall_u), 32'd1);
        Reset = 1'b0; ALUop = 4'd0; ResWrite = 1'b0;
        tick();
        check("midreset_stall_after", 32'(stall_u), 32'd0);
        check("midreset_hold", 32'(res_u), 32'd0);
        $display("[TB] midreset res=0x%h stall=%0b", res_u, stall_u);

        // Abort mid-RUN by switching to OR
        ALUop = 4'd7; ALUInA = 16'h0A0A; ALUInB = 16'h5050; ResSource = 1'b0; ResWrite = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("abort_stall_run", 32'(stall_u), 32'd1);
        do_op("abort_or", 1, 16'h0A0A, 16'h5050, 1'b0, 1'b1, 16'h0000);
        do_op("abort_after", 2, 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
